// File: rtl/sha256_padder.sv
// Streaming SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends 0x80 / zero fill / 64-bit bit length, and hands each block to the core.
module sha256_padder #(
    parameter int unsigned LEN_W = 64
) (
    input  logic         iClk,
    input  logic         iReset_n,
    input  logic         iIn_valid,
    output logic         oIn_ready,
    input  logic [31:0]  iIn_data,
    input  logic         iIn_last,
    input  logic [2:0]   iIn_bytes,
    output logic [511:0] oBlock,
    output logic         oStart,
    output logic         oLast_block,
    input  logic         iCore_done,
    output logic         oMsg_done,
    output logic         oBusy
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned NWORDS = 16;
    localparam int unsigned IDX_W  = 5;

    typedef enum logic [2:0] {FILL, PAD, LEN, ISSUE, WAIT} state_t;

    state_t                   state, state_n;
    logic [IDX_W-1:0]         idx, idx_n, idx_inc;
    logic [LEN_W-1:0]         len, len_n;
    logic                     pend, pend_n;
    logic                     tail, tail_n;
    logic [NWORDS*WORD_W-1:0] blk_n;
    logic                     start_n, lastb_n, mdone_n, busy_n;
    logic                     wr_en, adv;
    logic [WORD_W-1:0]        wr_word, tail_word;
    logic [2:0]               b_eff;
    logic [4:0]               sh;

    assign oIn_ready = (state == FILL);

    // State and datapath registers
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state       <= FILL;
            idx         <= '0;
            len         <= '0;
            pend        <= 1'b0;
            tail        <= 1'b0;
            oBlock      <= '0;
            oStart      <= 1'b0;
            oLast_block <= 1'b0;
            oMsg_done   <= 1'b0;
            oBusy       <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            len         <= len_n;
            pend        <= pend_n;
            tail        <= tail_n;
            oBlock      <= blk_n;
            oStart      <= start_n;
            oLast_block <= lastb_n;
            oMsg_done   <= mdone_n;
            oBusy       <= busy_n;
        end
    end

    // Next-state, word placement and output pulses
    always_comb begin
        state_n = state;
        idx_n   = idx;
        len_n   = len;
        pend_n  = pend;
        tail_n  = tail;
        blk_n   = oBlock;
        start_n = 1'b0;
        lastb_n = oLast_block;
        mdone_n = 1'b0;
        wr_en   = 1'b0;
        adv     = 1'b0;
        wr_word = '0;
        idx_inc = idx + IDX_W'(1);
        b_eff   = (iIn_bytes > 3'd4) ? 3'd4 : iIn_bytes;
        sh      = {b_eff[1:0], 3'b000};
        // keep the valid leading bytes and drop the 0x80 marker right behind them
        tail_word = (iIn_data & ~(32'hFFFF_FFFF >> sh)) | (32'h8000_0000 >> sh);

        case (state)
            FILL: begin
                if (iIn_valid) begin
                    wr_en = 1'b1;
                    idx_n = idx_inc;
                    if (iIn_last) begin
                        tail_n = 1'b1;
                        adv    = 1'b1;
                        len_n  = len + LEN_W'({b_eff, 3'b000});
                        if (b_eff == 3'd4) begin
                            wr_word = iIn_data;
                            pend_n  = 1'b1;
                        end else begin
                            wr_word = tail_word;
                        end
                    end else begin
                        wr_word = iIn_data;
                        len_n   = len + LEN_W'(WORD_W);
                        if (idx_inc == IDX_W'(NWORDS)) begin
                            state_n = ISSUE;
                            start_n = 1'b1;
                            lastb_n = 1'b0;
                        end
                    end
                end
            end
            PAD: begin
                wr_en   = 1'b1;
                wr_word = pend ? 32'h8000_0000 : '0;
                pend_n  = 1'b0;
                idx_n   = idx_inc;
                adv     = 1'b1;
            end
            LEN: begin
                blk_n[63:0] = 64'(len);
                state_n     = ISSUE;
                start_n     = 1'b1;
                lastb_n     = 1'b1;
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (iCore_done) begin
                    idx_n = '0;
                    if (oLast_block) begin
                        mdone_n = 1'b1;
                        len_n   = '0;
                        lastb_n = 1'b0;
                        tail_n  = 1'b0;
                        state_n = FILL;
                    end else begin
                        state_n = tail ? PAD : FILL;
                    end
                end
            end
            default: state_n = FILL;
        endcase

        // After a padding-phase write: spill to a second block, or go write the length
        if (adv) begin
            if (idx_n == IDX_W'(NWORDS)) begin
                state_n = ISSUE;
                start_n = 1'b1;
                lastb_n = 1'b0;
            end else if (idx_n == IDX_W'(14) && !pend_n) begin
                state_n = LEN;
            end else begin
                state_n = PAD;
            end
        end

        if (wr_en) begin
            for (int i = 0; i < int'(NWORDS); i++) begin
                if (idx[3:0] == 4'(i)) blk_n[(15-i)*WORD_W +: WORD_W] = wr_word;
            end
        end

        busy_n = !(state_n == FILL && idx_n == '0 && len_n == '0);
    end

endmodule
